// File: rtl/part_1_init_lockstep.sv
// Initiator-side lockstep controller: snapshots part-1 write channels on each
// mission-clock edge, ships them to the target and freezes the clock until the response returns.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | mission clock running, waiting for a clk_0_h rising edge
// SEND     | streaming snapshot vectors idx 0..NUM_CH-1 to the transport
// WAIT_RSP | all vectors sent, clock frozen, waiting for target response
// ERROR    | watchdog expired; clock stays frozen until reset
module part_1_init_lockstep #(
    parameter int N            = 9,
    parameter int NUM_CH       = 3,
    parameter int WATCHDOG_MAX = 10000,
    parameter int WD_W         = 14
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clk_0_h,
    input  logic         run_en,
    input  logic         wen0,
    input  logic         wen1,
    input  logic         wen2,
    input  logic [7:0]   i_data0,
    input  logic [7:0]   i_data1,
    input  logic [7:0]   i_data2,
    output logic [3:0]   freeze_clk,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [1:0]   tx_index,
    output logic [N-1:0] tx_payload,
    input  logic         rx_valid,
    input  logic [N-1:0] rx_payload,
    output logic         valid,
    output logic [7:0]   o_data,
    output logic         busy,
    output logic         wd_error,
    output logic         ovr_error
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam logic [1:0]      LAST_IDX = 2'(NUM_CH - 1);
    // Watchdog is a down-counter: loaded on WAIT_RSP entry, expires at zero.
    localparam logic [WD_W-1:0] WD_LOAD  = WD_W'(WATCHDOG_MAX - 1);

    state_t                      state_q, state_d;
    logic [1:0]                  idx_q, idx_d;
    logic [WD_W-1:0]             wd_q, wd_d;
    logic                        clk_0_d;
    logic [NUM_CH-1:0][N-1:0]    snap_q, snap_d;
    logic                        freeze_q, freeze_d;
    logic                        valid_q, valid_d;
    logic [7:0]                  o_data_q, o_data_d;
    logic                        wd_error_q, wd_error_d;
    logic                        ovr_error_q, ovr_error_d;
    logic                        mission_edge;
    logic [N-1:0]                cur_payload;

    assign mission_edge = clk_0_h & ~clk_0_d;

    always_comb begin
        case (idx_q)
            2'd1:    cur_payload = snap_q[1];
            2'd2:    cur_payload = snap_q[2];
            default: cur_payload = snap_q[0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wd_d        = wd_q;
        snap_d      = snap_q;
        freeze_d    = freeze_q;
        valid_d     = valid_q;
        o_data_d    = o_data_q;
        wd_error_d  = wd_error_q;
        ovr_error_d = ovr_error_q;
        tx_valid    = 1'b0;
        tx_index    = 2'd0;
        tx_payload  = '0;

        case (state_q)
            IDLE: begin
                if (mission_edge && run_en) begin
                    snap_d[0] = {wen0, i_data0};
                    snap_d[1] = {wen1, i_data1};
                    snap_d[2] = {wen2, i_data2};
                    idx_d     = 2'd0;
                    freeze_d  = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                tx_valid   = 1'b1;
                tx_index   = idx_q;
                tx_payload = cur_payload;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 2'd0;
                        wd_d    = WD_LOAD;
                        state_d = WAIT_RSP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            WAIT_RSP: begin
                if (rx_valid) begin
                    valid_d  = rx_payload[N-1];
                    o_data_d = rx_payload[7:0];
                    freeze_d = 1'b0;
                    state_d  = IDLE;
                end else if (wd_q == '0) begin
                    wd_error_d = 1'b1;
                    state_d    = ERROR;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
            end
            default: begin
                // ERROR absorbs everything, including rx_valid, until reset.
                freeze_d = 1'b1;
            end
        endcase

        if (mission_edge && (state_q != IDLE)) begin
            ovr_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            wd_q        <= '0;
            clk_0_d     <= 1'b0;
            snap_q      <= '0;
            freeze_q    <= 1'b0;
            valid_q     <= 1'b0;
            o_data_q    <= 8'h00;
            wd_error_q  <= 1'b0;
            ovr_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            clk_0_d     <= clk_0_h;
            snap_q      <= snap_d;
            freeze_q    <= freeze_d;
            valid_q     <= valid_d;
            o_data_q    <= o_data_d;
            wd_error_q  <= wd_error_d;
            ovr_error_q <= ovr_error_d;
        end
    end

    assign freeze_clk = {3'b000, freeze_q};
    assign valid      = valid_q;
    assign o_data     = o_data_q;
    assign busy       = (state_q != IDLE);
    assign wd_error   = wd_error_q;
    assign ovr_error  = ovr_error_q;

endmodule
